// File: rtl/aes_inv_sbox_engine.sv
// AES InvSubBytes engine: substitutes a 128-bit state through the FIPS-197
// inverse S-box, LANES bytes per clock, behind valid/ready handshakes.
// Handshake rule: a transfer happens on a rising clock edge where both valid
// and ready are high; valid and data hold steady until that transfer.
module aes_inv_sbox_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NGRP = 16 / LANES;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 InvSbox, element 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    work_q;
    logic [127:0]    sub_data;
    logic [127:0]    out_data_q;
    logic            last_grp;

    assign last_grp  = (cnt_q == CW'(NGRP - 1));
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

    // Working register with the current group's bytes run through the table.
    always_comb begin
        sub_data = work_q;
        for (int l = 0; l < LANES; l++) begin
            int base;
            base = int'(cnt_q) * LANES + l;
            sub_data[127 - 8 * base -: 8] = INV_SBOX[work_q[127 - 8 * base -: 8]];
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (last_grp) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, group counter, working register and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    work_q <= sub_data;
                    if (last_grp) begin
                        out_data_q <= sub_data;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
